// File: rtl/vol_ctrl.sv
// vol_ctrl: two-button volume/mute controller with debouncing, auto-repeat,
// saturating volume arithmetic, req/ack output handshake and OSD timer.
module vol_ctrl #(
    parameter int unsigned DEB_CYCLES  = 250000,
    parameter int unsigned RPT_DELAY   = 12500000,
    parameter int unsigned RPT_PERIOD  = 2500000,
    parameter int unsigned VOL_MAX     = 31,
    parameter int unsigned VOL_DEFAULT = 20
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic       BTN_volminus,
    input  logic       BTN_volplus,
    input  logic       upd_ack,
    output logic [4:0] vol_out,
    output logic       mute_out,
    output logic       upd_req,
    output logic       osd_active
);

    localparam int unsigned DW   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned OW   = $clog2(2 * RPT_DELAY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_HOLD,
        S_REPEAT,
        S_MUTE_LOCK
    } state_t;

    // Button index 1 = plus, 0 = minus; levels are active-low.
    logic [1:0]    raw;
    logic [1:0]    s1_q, s2_q, db_q, arm_q;
    logic [DW-1:0] dcnt_q [2];
    logic [1:0]    pressed;

    state_t        state_q, state_d;
    logic          dir_q, dir_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [4:0]    vol_q, vol_d;
    logic          mute_q, mute_d;
    logic          step, toggle;
    logic          active, other;

    logic [4:0]    vol_out_q;
    logic          mute_out_q, upd_req_q;
    logic          osd_q;
    logic [OW-1:0] ocnt_q;

    assign raw = {BTN_volplus, BTN_volminus};

    // Synchronize and debounce both buttons. A button stays unarmed after
    // reset until it has been seen stably released, so a press held through
    // reset is ignored until it is released and pressed again.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            s1_q  <= '1;
            s2_q  <= '1;
            db_q  <= '1;
            arm_q <= '0;
            for (int unsigned i = 0; i < 2; i++) dcnt_q[i] <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (!arm_q[i]) begin
                    if (s2_q[i]) begin
                        if (dcnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                            arm_q[i]  <= 1'b1;
                            dcnt_q[i] <= '0;
                        end else begin
                            dcnt_q[i] <= dcnt_q[i] + 1'b1;
                        end
                    end else begin
                        dcnt_q[i] <= '0;
                    end
                end else if (s2_q[i] != db_q[i]) begin
                    if (dcnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                        db_q[i]   <= s2_q[i];
                        dcnt_q[i] <= '0;
                    end else begin
                        dcnt_q[i] <= dcnt_q[i] + 1'b1;
                    end
                end else begin
                    dcnt_q[i] <= '0;
                end
            end
        end
    end

    assign pressed = arm_q & ~db_q;
    assign active  = dir_q ? pressed[1] : pressed[0];
    assign other   = dir_q ? pressed[0] : pressed[1];

    // Step FSM next state, step/mute-toggle strobes and saturating volume update.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        tmr_d   = tmr_q;
        step    = 1'b0;
        toggle  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (&pressed) begin
                    toggle  = 1'b1;
                    state_d = S_MUTE_LOCK;
                end else if (|pressed) begin
                    dir_d   = pressed[1];
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                step    = 1'b1;
                tmr_d   = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (other) begin
                    toggle  = 1'b1;
                    state_d = S_MUTE_LOCK;
                end else if (!active) begin
                    state_d = S_IDLE;
                end else if (tmr_q == TW'(RPT_DELAY - 1)) begin
                    tmr_d   = '0;
                    state_d = S_REPEAT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_REPEAT: begin
                if (other) begin
                    toggle  = 1'b1;
                    state_d = S_MUTE_LOCK;
                end else if (!active) begin
                    state_d = S_IDLE;
                end else if (tmr_q == TW'(RPT_PERIOD - 1)) begin
                    step  = 1'b1;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_MUTE_LOCK: begin
                if (pressed == 2'b00) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        vol_d  = vol_q;
        mute_d = mute_q;
        if (step) begin
            mute_d = 1'b0;
            if (dir_q) begin
                if (vol_q != 5'(VOL_MAX)) vol_d = vol_q + 5'd1;
            end else begin
                if (vol_q != 5'd0) vol_d = vol_q - 5'd1;
            end
        end else if (toggle) begin
            mute_d = ~mute_q;
        end
    end

    // FSM state, repeat timer and internal volume/mute registers.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            tmr_q   <= '0;
            vol_q   <= 5'(VOL_DEFAULT);
            mute_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            tmr_q   <= tmr_d;
            vol_q   <= vol_d;
            mute_q  <= mute_d;
        end
    end

    // Output handshake: load only when idle and ack is low; hold until acked.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            vol_out_q  <= 5'(VOL_DEFAULT);
            mute_out_q <= 1'b0;
            upd_req_q  <= 1'b1;
        end else if (upd_req_q) begin
            if (upd_ack) upd_req_q <= 1'b0;
        end else if (!upd_ack && ((vol_q != vol_out_q) || (mute_q != mute_out_q))) begin
            vol_out_q  <= vol_q;
            mute_out_q <= mute_q;
            upd_req_q  <= 1'b1;
        end
    end

    // OSD timer: restarted by every step or mute toggle, expires after 2*RPT_DELAY.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            osd_q  <= 1'b0;
            ocnt_q <= '0;
        end else if (step || toggle) begin
            osd_q  <= 1'b1;
            ocnt_q <= '0;
        end else if (osd_q) begin
            if (ocnt_q == OW'(2 * RPT_DELAY - 1)) begin
                osd_q  <= 1'b0;
                ocnt_q <= '0;
            end else begin
                ocnt_q <= ocnt_q + 1'b1;
            end
        end
    end

    assign vol_out    = vol_out_q;
    assign mute_out   = mute_out_q;
    assign upd_req    = upd_req_q;
    assign osd_active = osd_q;

endmodule

// File: tb/tb_vol_ctrl.sv
// Directed self-checking bench for vol_ctrl with upd_ack looped back from
// upd_req through a 2-cycle delay (optionally forced low).
module tb_vol_ctrl;

    logic       clk25 = 1'b0;
    logic       reset_n;
    logic       BTN_volminus, BTN_volplus;
    logic       upd_ack;
    logic [4:0] vol_out;
    logic       mute_out, upd_req, osd_active;

    logic [1:0] ack_pipe;
    logic       hold_ack;
    logic       req_prev;
    int         loads;
    int         base;
    int         checks   = 0;
    int         failures = 0;

    vol_ctrl #(
        .DEB_CYCLES (4),
        .RPT_DELAY  (20),
        .RPT_PERIOD (5),
        .VOL_MAX    (31),
        .VOL_DEFAULT(20)
    ) dut (
        .clk25       (clk25),
        .reset_n     (reset_n),
        .BTN_volminus(BTN_volminus),
        .BTN_volplus (BTN_volplus),
        .upd_ack     (upd_ack),
        .vol_out     (vol_out),
        .mute_out    (mute_out),
        .upd_req     (upd_req),
        .osd_active  (osd_active)
    );

    always #5 clk25 = ~clk25;

    // Acknowledge loopback: upd_req delayed by two cycles.
    always @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) ack_pipe <= 2'b00;
        else          ack_pipe <= {ack_pipe[0], upd_req};
    end
    assign upd_ack = ack_pipe[1] & ~hold_ack;

    // Count output loads as rising edges of upd_req.
    initial begin
        req_prev = 1'b0;
        loads    = 0;
        forever begin
            @(negedge clk25);
            if (upd_req && !req_prev) loads++;
            req_prev = upd_req;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk25);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Press one button (1 = plus, 0 = minus) for n cycles, then release and settle.
    task automatic press(input int btn, input int n, input int gap);
        if (btn == 1) BTN_volplus = 1'b0; else BTN_volminus = 1'b0;
        tick(n);
        BTN_volplus  = 1'b1;
        BTN_volminus = 1'b1;
        tick(gap);
    endtask

    initial begin
        reset_n      = 1'b0;
        BTN_volminus = 1'b1;
        BTN_volplus  = 1'b1;
        hold_ack     = 1'b0;

        // Reset state
        tick(3);
        chk("rst_vol", 32'(vol_out), 32'd20);
        chk("rst_mute", 32'(mute_out), 32'd0);
        chk("rst_req", 32'(upd_req), 32'd1);
        chk("rst_osd", 32'(osd_active), 32'd0);

        // Default pushed downstream after reset release
        reset_n = 1'b1;
        base = loads;
        tick(12);
        chk("boot_req_done", 32'(upd_req), 32'd0);
        chk("boot_vol", 32'(vol_out), 32'd20);
        chk("boot_osd", 32'(osd_active), 32'd0);
        chk("boot_no_reload", 32'(loads - base), 32'd0);

        // Short glitch ignored
        base = loads;
        press(1, 3, 20);
        chk("glitch_vol", 32'(vol_out), 32'd20);
        chk("glitch_loads", 32'(loads - base), 32'd0);
        chk("glitch_osd", 32'(osd_active), 32'd0);

        // Valid press: one step, one handshake, OSD on
        press(1, 10, 15);
        chk("plus_vol", 32'(vol_out), 32'd21);
        chk("plus_loads", 32'(loads - base), 32'd1);
        chk("plus_osd", 32'(osd_active), 32'd1);
        tick(30);
        chk("osd_expired", 32'(osd_active), 32'd0);

        // Both buttons together: mute toggles, volume kept
        BTN_volplus  = 1'b0;
        BTN_volminus = 1'b0;
        tick(15);
        chk("both_mute", 32'(mute_out), 32'd1);
        chk("both_vol", 32'(vol_out), 32'd21);
        BTN_volplus  = 1'b1;
        BTN_volminus = 1'b1;
        tick(15);
        press(0, 10, 15);
        chk("unmute_mute", 32'(mute_out), 32'd0);
        chk("unmute_vol", 32'(vol_out), 32'd20);

        // Ack withheld across three steps: outputs frozen, then latest value
        hold_ack = 1'b1;
        base = loads;
        press(1, 10, 15);
        press(1, 10, 15);
        press(1, 10, 15);
        chk("frozen_vol", 32'(vol_out), 32'd21);
        chk("frozen_req", 32'(upd_req), 32'd1);
        chk("frozen_loads", 32'(loads - base), 32'd1);
        hold_ack = 1'b0;
        tick(20);
        chk("final_vol", 32'(vol_out), 32'd23);
        chk("final_loads", 32'(loads - base), 32'd2);

        // Walk up to 29
        for (int i = 0; i < 6; i++) press(1, 10, 15);
        chk("walk_vol", 32'(vol_out), 32'd29);

        // Hold plus 50 cycles from 29: 30, 31, then saturated
        base = loads;
        press(1, 50, 30);
        chk("sat_hi_vol", 32'(vol_out), 32'd31);
        chk("sat_hi_loads", 32'(loads - base), 32'd2);
        chk("sat_hi_req", 32'(upd_req), 32'd0);

        // Hold minus long enough to reach 0, then keep holding at 0
        BTN_volminus = 1'b0;
        tick(250);
        base = loads;
        tick(40);
        chk("sat_lo_vol", 32'(vol_out), 32'd0);
        chk("sat_lo_loads", 32'(loads - base), 32'd0);
        chk("sat_lo_osd", 32'(osd_active), 32'd1);
        BTN_volminus = 1'b1;
        tick(20);

        // Reset during REPEAT with plus held
        BTN_volplus = 1'b0;
        tick(40);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_vol", 32'(vol_out), 32'd20);
        chk("mid_rst_req", 32'(upd_req), 32'd1);
        chk("mid_rst_osd", 32'(osd_active), 32'd0);
        chk("mid_rst_mute", 32'(mute_out), 32'd0);
        tick(3);
        reset_n = 1'b1;
        tick(40);
        chk("held_ignored_vol", 32'(vol_out), 32'd20);
        chk("held_ignored_osd", 32'(osd_active), 32'd0);
        chk("held_ignored_req", 32'(upd_req), 32'd0);
        BTN_volplus = 1'b1;
        tick(15);
        press(1, 10, 15);
        chk("repress_vol", 32'(vol_out), 32'd21);
        chk("repress_osd", 32'(osd_active), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
